// File: rtl/robo_ambiente_pkg.sv
// Shared definitions for the maze-robot world model: headings, grid size and
// neighbour-cell helpers used by both the top level and the sensor block.
package robo_pkg;

   localparam int GRID = 8;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic       oob;
   } viz_t;

   function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
      return {y, x};
   endfunction

   // Coordinates wrap when oob is set; callers must treat oob as a wall.
   function automatic viz_t vizinho(input logic [2:0] x, input logic [2:0] y,
                                    input logic [1:0] d);
      viz_t v;
      v.x   = x;
      v.y   = y;
      v.oob = 1'b0;
      case (d)
         DIR_N: begin v.oob = (y == 3'd0);            v.y = y - 3'd1; end
         DIR_E: begin v.oob = (x == 3'(GRID - 1));    v.x = x + 3'd1; end
         DIR_S: begin v.oob = (y == 3'(GRID - 1));    v.y = y + 3'd1; end
         default: begin v.oob = (x == 3'd0);          v.x = x - 3'd1; end
      endcase
      return v;
   endfunction

endpackage

// File: rtl/robo_ambiente_if.sv
// Command/sensor bundle between the robot controller (master) and the world
// model (slave), plus pose/status taps for displays.
interface robo_ambiente_if;
   logic        avancar;
   logic        girar;
   logic        remover;
   logic        head;
   logic        left;
   logic        under;
   logic        barrier;
   logic [2:0]  pos_x;
   logic [2:0]  pos_y;
   logic [1:0]  dir;
   logic        crash;
   logic        cmd_err;
   logic [15:0] passos;

   modport master (
      output avancar, girar, remover,
      input  head, left, under, barrier, pos_x, pos_y, dir, crash, cmd_err, passos
   );

   modport slave (
      input  avancar, girar, remover,
      output head, left, under, barrier, pos_x, pos_y, dir, crash, cmd_err, passos
   );
endinterface

// File: rtl/robo_ambiente_vizinhanca.sv
// Combinational sensor block: looks at the cells ahead of and to the left of
// the robot and reports walls, debris and the ahead-cell index.
module robo_vizinhanca
   import robo_pkg::*;
(
   input  logic [2:0]  pos_x,
   input  logic [2:0]  pos_y,
   input  logic [1:0]  dir,
   input  logic [63:0] walls,
   input  logic [63:0] debris,
   output logic        head,
   output logic        left,
   output logic        barrier,
   output logic [5:0]  ahead_idx
);

   viz_t ahead;
   viz_t side;

   assign ahead     = vizinho(pos_x, pos_y, dir);
   // Left of the current heading is one counter-clockwise step.
   assign side      = vizinho(pos_x, pos_y, dir - 2'd1);
   assign ahead_idx = cell_idx(ahead.x, ahead.y);

   assign head    = ahead.oob | walls[ahead_idx];
   assign left    = side.oob | walls[cell_idx(side.x, side.y)];
   assign barrier = ~head & debris[ahead_idx];

endmodule

// File: rtl/robo_ambiente.sv
// Cycle-accurate 8x8 maze world: applies the controller's motion commands to
// the robot pose and debris map and drives the sensor bits back.
module robo_ambiente
   import robo_pkg::*;
#(
   parameter logic [63:0] WALLS       = 64'h0,
   parameter logic [63:0] DEBRIS_INIT = 64'h0,
   parameter int          START_X     = 0,
   parameter int          START_Y     = 0,
   parameter int          START_DIR   = 1,
   parameter int          EXIT_X      = 7,
   parameter int          EXIT_Y      = 7
) (
   input  logic             clock,
   input  logic             reset,
   robo_ambiente_if.slave   bus
);

   localparam logic [2:0]  SX = 3'(START_X);
   localparam logic [2:0]  SY = 3'(START_Y);
   localparam logic [1:0]  SD = 2'(START_DIR);
   localparam logic [2:0]  EX = 3'(EXIT_X);
   localparam logic [2:0]  EY = 3'(EXIT_Y);

   logic [2:0]  pos_x, pos_y;
   logic [1:0]  dir;
   logic [63:0] debris;
   logic [1:0]  rem_cnt;
   logic        crash, cmd_err;
   logic [15:0] passos;

   logic        head, left, barrier, under;
   logic [5:0]  ahead_idx;
   logic [1:0]  n_cmd;
   logic        multi;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   robo_vizinhanca u_viz (
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .dir       (dir),
      .walls     (WALLS),
      .debris    (debris),
      .head      (head),
      .left      (left),
      .barrier   (barrier),
      .ahead_idx (ahead_idx)
   );

   assign under = (pos_x == EX) && (pos_y == EY);
   assign n_cmd = 2'(bus.avancar) + 2'(bus.girar) + 2'(bus.remover);
   assign multi = (n_cmd > 2'd1);

   always_ff @(posedge clock) begin
      if (reset) begin
         pos_x   <= SX;
         pos_y   <= SY;
         dir     <= SD;
         debris  <= DEBRIS_INIT & ~WALLS;
         rem_cnt <= 2'd0;
         crash   <= 1'b0;
         cmd_err <= 1'b0;
         passos  <= 16'd0;
      end else begin
         if (multi) cmd_err <= 1'b1;
         // Reaching the exit freezes everything except command-conflict detection.
         if (!under) begin
            if (multi) begin
               rem_cnt <= 2'd0;
            end else if (bus.avancar) begin
               rem_cnt <= 2'd0;
               if (!head && !barrier) begin
                  pos_x  <= ahead_idx[2:0];
                  pos_y  <= ahead_idx[5:3];
                  passos <= sat_inc(passos);
               end else begin
                  crash <= 1'b1;
               end
            end else if (bus.girar) begin
               rem_cnt <= 2'd0;
               dir     <= dir - 2'd1;
               passos  <= sat_inc(passos);
            end else if (bus.remover && barrier) begin
               if (rem_cnt == 2'd2) begin
                  debris[ahead_idx] <= 1'b0;
                  rem_cnt           <= 2'd0;
               end else begin
                  rem_cnt <= rem_cnt + 2'd1;
               end
            end else begin
               rem_cnt <= 2'd0;
            end
         end
      end
   end

   assign bus.head    = head;
   assign bus.left    = left;
   assign bus.barrier = barrier;
   assign bus.under   = under;
   assign bus.pos_x   = pos_x;
   assign bus.pos_y   = pos_y;
   assign bus.dir     = dir;
   assign bus.crash   = crash;
   assign bus.cmd_err = cmd_err;
   assign bus.passos  = passos;

endmodule

// File: tb/tb_robo_ambiente.sv
// Scoreboard bench for robo_ambiente: three worlds (empty, debris ahead, exit
// ahead) driven with directed command sequences.
module tb_robo_ambiente;
   import robo_pkg::*;

   typedef struct packed {
      logic [2:0]  x;
      logic [2:0]  y;
      logic [1:0]  d;
      logic        head;
      logic        left;
      logic        under;
      logic        barrier;
      logic        crash;
      logic        cmd_err;
      logic [15:0] passos;
   } obs_t;

   typedef struct packed {
      logic [1:0] inst;
      int         cyc;
      obs_t       o;
   } exp_t;

   localparam logic [2:0] C_NONE = 3'b000;
   localparam logic [2:0] C_AV   = 3'b100;
   localparam logic [2:0] C_GI   = 3'b010;
   localparam logic [2:0] C_RM   = 3'b001;

   logic clock = 1'b0;
   logic reset;
   logic [2:0] cmd_a, cmd_b, cmd_c;
   int cycnt = 0;
   int n_tests = 0;
   int n_fail = 0;
   exp_t  exp_q[$];
   string name_q[$];

   always #5 clock = ~clock;
   always @(posedge clock) cycnt++;

   robo_ambiente_if bus_a();
   robo_ambiente_if bus_b();
   robo_ambiente_if bus_c();

   assign {bus_a.avancar, bus_a.girar, bus_a.remover} = cmd_a;
   assign {bus_b.avancar, bus_b.girar, bus_b.remover} = cmd_b;
   assign {bus_c.avancar, bus_c.girar, bus_c.remover} = cmd_c;

   robo_ambiente #(.WALLS(64'h0), .DEBRIS_INIT(64'h0), .START_X(0), .START_Y(0),
                   .START_DIR(1), .EXIT_X(7), .EXIT_Y(7))
      dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));

   // Debris at (1,0): bit 0*8+1.
   robo_ambiente #(.WALLS(64'h0), .DEBRIS_INIT(64'h2), .START_X(0), .START_Y(0),
                   .START_DIR(1), .EXIT_X(7), .EXIT_Y(7))
      dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

   robo_ambiente #(.WALLS(64'h0), .DEBRIS_INIT(64'h0), .START_X(0), .START_Y(0),
                   .START_DIR(1), .EXIT_X(1), .EXIT_Y(0))
      dut_c (.clock(clock), .reset(reset), .bus(bus_c.slave));

   function automatic obs_t mk(int x, int y, int d, bit hd, bit lf, bit un, bit br,
                               bit cr, bit er, int ps);
      obs_t o;
      o.x = 3'(x); o.y = 3'(y); o.d = 2'(d);
      o.head = hd; o.left = lf; o.under = un; o.barrier = br;
      o.crash = cr; o.cmd_err = er; o.passos = 16'(ps);
      return o;
   endfunction

   function automatic obs_t obs_of(logic [1:0] inst);
      obs_t o;
      case (inst)
         2'd0: o = {bus_a.pos_x, bus_a.pos_y, bus_a.dir, bus_a.head, bus_a.left, bus_a.under,
                    bus_a.barrier, bus_a.crash, bus_a.cmd_err, bus_a.passos};
         2'd1: o = {bus_b.pos_x, bus_b.pos_y, bus_b.dir, bus_b.head, bus_b.left, bus_b.under,
                    bus_b.barrier, bus_b.crash, bus_b.cmd_err, bus_b.passos};
         default: o = {bus_c.pos_x, bus_c.pos_y, bus_c.dir, bus_c.head, bus_c.left, bus_c.under,
                       bus_c.barrier, bus_c.crash, bus_c.cmd_err, bus_c.passos};
      endcase
      return o;
   endfunction

   // Drive one command for one edge and queue the state expected after it.
   task automatic step(input logic [1:0] inst, input logic [2:0] c, input obs_t e,
                       input string nm);
      exp_t x;
      case (inst)
         2'd0: cmd_a = c;
         2'd1: cmd_b = c;
         default: cmd_c = c;
      endcase
      x.inst = inst;
      x.cyc  = cycnt + 1;
      x.o    = e;
      exp_q.push_back(x);
      name_q.push_back(nm);
      @(negedge clock);
      cmd_a = C_NONE;
      cmd_b = C_NONE;
      cmd_c = C_NONE;
   endtask

   // Monitor: compares every expectation due at this negedge.
   always @(negedge clock) begin
      exp_t  e;
      string nm;
      obs_t  act;
      while (exp_q.size() > 0 && exp_q[0].cyc == cycnt) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = obs_of(e.inst);
         n_tests++;
         if (act !== e.o) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d d=%0d h=%b l=%b u=%b b=%b cr=%b er=%b p=%0d, want x=%0d y=%0d d=%0d h=%b l=%b u=%b b=%b cr=%b er=%b p=%0d",
                     nm, act.x, act.y, act.d, act.head, act.left, act.under, act.barrier,
                     act.crash, act.cmd_err, act.passos,
                     e.o.x, e.o.y, e.o.d, e.o.head, e.o.left, e.o.under, e.o.barrier,
                     e.o.crash, e.o.cmd_err, e.o.passos);
         end
      end
   end

   initial begin
      reset = 1'b1;
      cmd_a = C_NONE;
      cmd_b = C_NONE;
      cmd_c = C_NONE;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // World A: empty map
      step(0, C_NONE, mk(0,0,1, 0,1,0,0, 0,0,0), "a_reset");
      step(0, C_AV,   mk(1,0,1, 0,1,0,0, 0,0,1), "a_av1");
      step(0, C_AV,   mk(2,0,1, 0,1,0,0, 0,0,2), "a_av2");
      step(0, C_AV,   mk(3,0,1, 0,1,0,0, 0,0,3), "a_av3");
      step(0, C_GI,   mk(3,0,0, 1,0,0,0, 0,0,4), "a_turn_n");
      step(0, C_AV,   mk(3,0,0, 1,0,0,0, 1,0,4), "a_crash_oob");
      step(0, C_AV | C_GI, mk(3,0,0, 1,0,0,0, 1,1,4), "a_cmd_err");
      step(0, C_GI,   mk(3,0,3, 0,0,0,0, 1,1,5), "a_turn_w");

      // World C: exit one cell east
      step(2, C_NONE, mk(0,0,1, 0,1,0,0, 0,0,0), "c_reset");
      step(2, C_AV,   mk(1,0,1, 0,1,1,0, 0,0,1), "c_reach_exit");
      step(2, C_AV,   mk(1,0,1, 0,1,1,0, 0,0,1), "c_frozen_av");
      step(2, C_GI,   mk(1,0,1, 0,1,1,0, 0,0,1), "c_frozen_gi");
      step(2, C_AV | C_GI, mk(1,0,1, 0,1,1,0, 0,1,1), "c_frozen_cmd_err");

      // World B: debris one cell east
      step(1, C_NONE, mk(0,0,1, 0,1,0,1, 0,0,0), "b_reset");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_rm1");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_rm2");
      step(1, C_NONE, mk(0,0,1, 0,1,0,1, 0,0,0), "b_idle_keeps");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_rm_again1");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_rm_again2");
      step(1, C_RM,   mk(0,0,1, 0,1,0,0, 0,0,0), "b_rm_cleared");
      step(1, C_AV,   mk(1,0,1, 0,1,0,0, 0,0,1), "b_av_after_clear");

      // Reset mid-run, then mid-removal
      reset = 1'b1;
      step(1, C_GI,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_reset_run");
      reset = 1'b0;
      step(1, C_GI,   mk(0,0,0, 1,1,0,0, 0,0,1), "b_turn_n");
      step(1, C_GI,   mk(0,0,3, 1,0,0,0, 0,0,2), "b_turn_w");
      step(1, C_GI,   mk(0,0,2, 0,0,0,0, 0,0,3), "b_turn_s");
      step(1, C_GI,   mk(0,0,1, 0,1,0,1, 0,0,4), "b_turn_e");
      step(1, C_AV,   mk(0,0,1, 0,1,0,1, 1,0,4), "b_crash_debris");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 1,0,4), "b_rm1_pre_reset");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 1,0,4), "b_rm2_pre_reset");
      reset = 1'b1;
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_reset_mid_rm");
      reset = 1'b0;
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_post_rst_rm1");
      step(1, C_RM,   mk(0,0,1, 0,1,0,1, 0,0,0), "b_post_rst_rm2");
      step(1, C_RM,   mk(0,0,1, 0,1,0,0, 0,0,0), "b_post_rst_rm3");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
